// File: rtl/qam_pkg.sv
// Shared definitions for the 16QAM receive path.
//   - default sample width and calibration length
//   - offset-calibration FSM state enum
//   - saturation limit helpers, common to the offset stage and the demapper thresholds
package qam_pkg;

    localparam int unsigned QAM_WIDTH    = 8;
    localparam int unsigned QAM_CAL_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } cal_state_e;

    // Largest / smallest representable value of a signed w-bit sample.
    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/qam_offset_lane.sv
// One I or Q lane of the DC-offset calibration stage.
// Holds the calibration accumulator, the latched offset and the
// subtract/reduce datapath that produces the registered corrected sample.
// Optional feature macro: QAM_OFFSET_SAT_EN (saturate instead of wrap).
// Ports:
//   symbol_clock, rst  clock and synchronous active-high reset
//   acc_clear          zero the accumulator (calibration entry)
//   acc_en             add sample into the accumulator
//   offset_latch       latch (accumulator + sample) >>> CAL_LOG2 as the new offset
//   run                register the corrected sample
//   sample             raw signed input sample
//   corrected          registered offset-corrected sample
//   offset             latched signed offset
module qam_offset_lane
    import qam_pkg::*;
#(
    parameter int unsigned WIDTH    = QAM_WIDTH,
    parameter int unsigned CAL_LOG2 = QAM_CAL_LOG2
) (
    input  logic                    symbol_clock,
    input  logic                    rst,
    input  logic                    acc_clear,
    input  logic                    acc_en,
    input  logic                    offset_latch,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] corrected,
    output logic signed [WIDTH-1:0] offset
);

    localparam int unsigned AW = WIDTH + CAL_LOG2;

    logic [AW-1:0]    acc_q;
    logic [AW-1:0]    acc_sum;
    logic [WIDTH-1:0] corr_d;

    // Sum including the current sample, so the last accumulating edge can
    // latch the offset directly.
    assign acc_sum = acc_q + {{CAL_LOG2{sample[WIDTH-1]}}, sample};

`ifdef QAM_OFFSET_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

    logic [WIDTH:0] diff;

    assign diff = {sample[WIDTH-1], sample} - {offset[WIDTH-1], offset};

    // Top two bits disagree only when the difference left the WIDTH-bit range.
    always_comb begin
        corr_d = diff[WIDTH-1:0];
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            corr_d = diff[WIDTH] ? SAT_LO : SAT_HI;
        end
    end
`else
    // Low WIDTH bits of the wide difference equal the narrow difference.
    assign corr_d = sample - offset;
`endif

    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            acc_q     <= '0;
            offset    <= '0;
            corrected <= '0;
        end else begin
            if (acc_clear) begin
                acc_q <= '0;
            end else if (acc_en) begin
                acc_q <= acc_sum;
            end
            // Arithmetic shift right by CAL_LOG2 == dropping the low bits.
            if (offset_latch) begin
                offset <= acc_sum[AW-1:CAL_LOG2];
            end
            if (run) begin
                corrected <= corr_d;
            end
        end
    end

endmodule

// File: rtl/qam_iq_offset_cal.sv
// DC-offset calibration stage ahead of the 16QAM hard-decision demapper.
// A calibration request averages 2^CAL_LOG2 signal-free samples per lane to
// measure the origin offset; in run mode the offset is subtracted from
// every sample. Optional feature macro: QAM_OFFSET_SAT_EN (saturating
// subtract; default build wraps).
// Ports:
//   symbol_clock, rst   clock and synchronous active-high reset
//   en                  run enable (level)
//   cal                 calibration request
//   I_in, Q_in          raw signed samples
//   I_out, Q_out        registered corrected samples
//   out_valid           I_out/Q_out were updated on the previous edge
//   cal_busy            calibration in progress
//   cal_done            one-cycle pulse when new offsets are latched
//   offset_I, offset_Q  latched offsets
module qam_iq_offset_cal
    import qam_pkg::*;
#(
    parameter int unsigned WIDTH    = QAM_WIDTH,
    parameter int unsigned CAL_LOG2 = QAM_CAL_LOG2
) (
    input  logic                    symbol_clock,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cal,
    input  logic signed [WIDTH-1:0] I_in,
    input  logic signed [WIDTH-1:0] Q_in,
    output logic signed [WIDTH-1:0] I_out,
    output logic signed [WIDTH-1:0] Q_out,
    output logic                    out_valid,
    output logic                    cal_busy,
    output logic                    cal_done,
    output logic signed [WIDTH-1:0] offset_I,
    output logic signed [WIDTH-1:0] offset_Q
);

    localparam int unsigned   CW       = CAL_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((2 ** CAL_LOG2) - 1);

    cal_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_d, cal_busy_d, cal_done_d;
    logic          acc_clear, acc_en, offset_latch, run;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = 1'b0;
        cal_busy_d   = cal_busy;
        cal_done_d   = 1'b0;
        acc_clear    = 1'b0;
        acc_en       = 1'b0;
        offset_latch = 1'b0;
        run          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cal) begin
                    state_d    = CAL;
                    acc_clear  = 1'b1;
                    cnt_d      = '0;
                    cal_busy_d = 1'b1;
                end else if (en) begin
                    state_d = RUN;
                end
            end
            CAL: begin
                // cal and en are deliberately ignored until completion.
                acc_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    offset_latch = 1'b1;
                    cal_done_d   = 1'b1;
                    cal_busy_d   = 1'b0;
                    cnt_d        = '0;
                    state_d      = en ? RUN : IDLE;
                end
            end
            RUN: begin
                if (cal) begin
                    // Old offsets keep applying until the new ones latch.
                    state_d    = CAL;
                    acc_clear  = 1'b1;
                    cnt_d      = '0;
                    cal_busy_d = 1'b1;
                end else if (en) begin
                    run         = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge symbol_clock) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            cal_busy  <= 1'b0;
            cal_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            cal_busy  <= cal_busy_d;
            cal_done  <= cal_done_d;
        end
    end

    qam_offset_lane #(
        .WIDTH    (WIDTH),
        .CAL_LOG2 (CAL_LOG2)
    ) u_lane_i (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .offset_latch (offset_latch),
        .run          (run),
        .sample       (I_in),
        .corrected    (I_out),
        .offset       (offset_I)
    );

    qam_offset_lane #(
        .WIDTH    (WIDTH),
        .CAL_LOG2 (CAL_LOG2)
    ) u_lane_q (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .offset_latch (offset_latch),
        .run          (run),
        .sample       (Q_in),
        .corrected    (Q_out),
        .offset       (offset_Q)
    );

endmodule

// File: tb/tb_qam_iq_offset_cal.sv
// Directed self-checking bench for qam_iq_offset_cal (WIDTH 8, CAL_LOG2 4).
module tb_qam_iq_offset_cal;

    logic              symbol_clock = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              cal = 1'b0;
    logic signed [7:0] I_in = '0;
    logic signed [7:0] Q_in = '0;
    logic signed [7:0] I_out, Q_out, offset_I, offset_Q;
    logic              out_valid, cal_busy, cal_done;

    int checks = 0;
    int errors = 0;

    qam_iq_offset_cal dut (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .en           (en),
        .cal          (cal),
        .I_in         (I_in),
        .Q_in         (Q_in),
        .I_out        (I_out),
        .Q_out        (Q_out),
        .out_valid    (out_valid),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .offset_I     (offset_I),
        .offset_Q     (offset_Q)
    );

    always #5 symbol_clock = ~symbol_clock;

    task automatic tick();
        @(posedge symbol_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Calibration request at edge 0, then 16 samples alternating a0/a1.
    // cal stays high for the first 'hold' sample edges to show it is ignored.
    task automatic do_cal(input logic signed [7:0] i0, input logic signed [7:0] i1,
                          input logic signed [7:0] q0, input logic signed [7:0] q1,
                          input logic en_v, input int hold);
        en  = en_v;
        cal = 1'b1;
        tick();
        check("cal_entry_busy", cal_busy, 1);
        check("cal_entry_done", cal_done, 0);
        check("cal_entry_valid", out_valid, 0);
        for (int k = 1; k <= 16; k++) begin
            cal  = (k <= hold);
            I_in = (k % 2 == 1) ? i0 : i1;
            Q_in = (k % 2 == 1) ? q0 : q1;
            tick();
            if (k < 16) begin
                check("cal_busy_mid", cal_busy, 1);
                check("cal_done_mid", cal_done, 0);
            end else begin
                check("cal_busy_end", cal_busy, 0);
                check("cal_done_end", cal_done, 1);
            end
            check("cal_valid", out_valid, 0);
        end
        cal = 1'b0;
    endtask

    initial begin
        // Reset with random inputs.
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            I_in = 8'($urandom);
            Q_in = 8'($urandom);
            en   = 1'($urandom);
            cal  = 1'($urandom);
            tick();
        end
        check("rst_I_out", I_out, 0);
        check("rst_Q_out", Q_out, 0);
        check("rst_offset_I", offset_I, 0);
        check("rst_offset_Q", offset_Q, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", cal_busy, 0);
        check("rst_done", cal_done, 0);
        rst = 1'b0;
        en  = 1'b0;
        cal = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("idle_valid", out_valid, 0);
            check("idle_busy", cal_busy, 0);
        end

        // Constant calibration, cal held through 8 samples (ignored).
        do_cal(8'sd10, 8'sd10, -8'sd6, -8'sd6, 1'b0, 8);
        check("const_offset_I", offset_I, 10);
        check("const_offset_Q", offset_Q, -6);
        tick();
        check("const_done_one_cycle", cal_done, 0);
        check("const_idle_valid", out_valid, 0);

        // Run correction.
        en   = 1'b1;
        I_in = 8'sd74;
        Q_in = 8'sd58;
        tick();
        tick();
        check("run_I_out", I_out, 64);
        check("run_Q_out", Q_out, 64);
        check("run_valid", out_valid, 1);
        I_in = 8'sd0;
        Q_in = 8'sd0;
        tick();
        check("run_zero_I", I_out, -10);
        check("run_zero_Q", Q_out, 6);
        en   = 1'b0;
        I_in = 8'sd33;
        tick();
        check("stop_valid", out_valid, 0);
        check("stop_hold_I", I_out, -10);
        tick();
        check("idle_hold_I", I_out, -10);
        check("persist_offset_I", offset_I, 10);

        // Negative floor: -24/16 -> -2; Q: 56/16 -> 3.
        do_cal(-8'sd1, -8'sd2, 8'sd3, 8'sd4, 1'b0, 0);
        check("floor_offset_I", offset_I, -2);
        check("floor_offset_Q", offset_Q, 3);
        tick();

        // Calibrate straight into RUN, then exceed the range.
        do_cal(-8'sd20, -8'sd20, 8'sd100, 8'sd100, 1'b1, 0);
        check("sat_offset_I", offset_I, -20);
        check("sat_offset_Q", offset_Q, 100);
        check("cal_to_run_valid", out_valid, 0);
        I_in = 8'sd120;
        Q_in = -8'sd100;
        tick();
        check("first_run_valid", out_valid, 1);
        check("first_run_done", cal_done, 0);
`ifdef QAM_OFFSET_SAT_EN
        check("sat_I_out", I_out, 127);
        check("sat_Q_out", Q_out, -128);
`else
        check("wrap_I_out", I_out, -116);
        check("wrap_Q_out", Q_out, 56);
`endif
        en = 1'b0;
        tick();
        check("sat_stop_valid", out_valid, 0);

        // Reset in the middle of a calibration.
        cal = 1'b1;
        tick();
        cal  = 1'b0;
        I_in = 8'sd5;
        Q_in = 8'sd5;
        for (int n = 0; n < 8; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_offset_I", offset_I, 0);
        check("midrst_offset_Q", offset_Q, 0);
        check("midrst_busy", cal_busy, 0);
        check("midrst_done", cal_done, 0);
        check("midrst_I_out", I_out, 0);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("midrst_no_done", cal_done, 0);
            check("midrst_no_busy", cal_busy, 0);
        end
        do_cal(8'sd7, 8'sd7, -8'sd3, -8'sd3, 1'b0, 0);
        check("recal_offset_I", offset_I, 7);
        check("recal_offset_Q", offset_Q, -3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
